eth_frame_extractor: RTL and testbench

- Sits directly downstream of eth_parser on the same receive GMII byte stream.
- Uses the parser's per-byte field flags to latch destination MAC, source MAC and EtherType into registers.
- Streams the payload with the 4-byte FCS stripped, and checks CRC-32 over destination MAC through FCS.
- Reports a per-frame status pulse to the MAC receive datapath.

---
 rtl/eth_parser_pkg.sv | 27 ++
 rtl/crc32_d8.sv | 31 +++
 rtl/eth_frame_extractor.sv | 218 +++++++++++++++++++++
 tb/tb_eth_frame_extractor.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_parser_pkg.sv
// ---------------------------------------------------------------------------
// eth_parser_pkg
// Shared types and constants for the receive-side Ethernet parsing blocks:
// the frame extractor FSM state type and the CRC-32 / framing constants.
// ---------------------------------------------------------------------------
package eth_parser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DONE    = 2'd3
    } extractor_state_t;

    // Reflected CRC-32 (IEEE 802.3)
    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    localparam int unsigned FCS_BYTES         = 4;
    localparam int unsigned MIN_PAYLOAD_BYTES = 46;

    // One byte beyond the FCS must be buffered before a payload byte is known
    // not to be part of the FCS.
    localparam int unsigned PAYLOAD_BUF_DEPTH = FCS_BYTES + 1;

endpackage : eth_parser_pkg

// File: rtl/crc32_d8.sv
// ---------------------------------------------------------------------------
// crc32_d8
// Combinational next-state function of the reflected CRC-32, consuming one
// byte per call, least significant data bit first.
// Ports:
//   crc_i  [31:0]  current CRC register
//   data_i [7:0]   byte to absorb
//   crc_o  [31:0]  CRC register after the byte
// ---------------------------------------------------------------------------
module crc32_d8
    import eth_parser_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        logic [31:0] c;
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_i[i]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_o = c;
    end

endmodule : crc32_d8

// File: rtl/eth_frame_extractor.sv
// ---------------------------------------------------------------------------
// eth_frame_extractor
// Follows eth_parser's per-byte field flags on the GMII receive stream,
// latches the MAC header fields, streams the payload with the FCS stripped,
// checks the CRC-32 and reports a per-frame status pulse.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   gmii_rx_data_i/valid_i         receive byte stream
//   is_*_i                         parser field flags for the current byte
//   err_preamble_sfd_i/incomplete_i parser error pulses
//   dst_mac_o/src_mac_o/ether_type_o latched header, first wire byte in MSBs
//   hdr_valid_o                    header fields updated this cycle
//   payload_data/valid/last_o      payload stream, FCS removed
//   frame_done_o                   end-of-frame pulse qualifying the next
//   fcs_ok_o/frame_err_o/frame_len_o frame status
// ---------------------------------------------------------------------------
module eth_frame_extractor
    import eth_parser_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD_BYTES = 1500,
    parameter int unsigned LEN_W             = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       gmii_rx_data_i,
    input  logic             gmii_rx_valid_i,
    input  logic             is_preamble_or_sfd_i,
    input  logic             is_dst_mac_i,
    input  logic             is_src_mac_i,
    input  logic             is_ether_type_i,
    input  logic             is_payload_or_fcs_i,
    input  logic             err_preamble_sfd_i,
    input  logic             err_incomplete_i,
    output logic [47:0]      dst_mac_o,
    output logic [47:0]      src_mac_o,
    output logic [15:0]      ether_type_o,
    output logic             hdr_valid_o,
    output logic [7:0]       payload_data_o,
    output logic             payload_valid_o,
    output logic             payload_last_o,
    output logic             frame_done_o,
    output logic             fcs_ok_o,
    output logic             frame_err_o,
    output logic [LEN_W-1:0] frame_len_o
);

    localparam int unsigned CNT_W = 3;

    extractor_state_t state_q;
    logic [47:0]      dst_sh_q;
    logic [47:0]      src_sh_q;
    logic [7:0]       et_hi_q;
    logic             et_cnt_q;
    logic [31:0]      crc_q;
    logic [31:0]      crc_d;
    logic             err_q;
    logic [7:0]       buf_q [PAYLOAD_BUF_DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;

    logic             byte_acc;
    logic             acc_pre;
    logic             acc_dst;
    logic             acc_pl;
    logic             buf_full;
    logic             clr;
    logic [LEN_W-1:0] len_inc;
    logic [LEN_W-1:0] len_fin;
    logic             len_bad;

    // A byte counts only when exactly one field flag claims it.
    assign byte_acc = gmii_rx_valid_i && $onehot({is_preamble_or_sfd_i, is_dst_mac_i,
                                                  is_src_mac_i, is_ether_type_i,
                                                  is_payload_or_fcs_i});
    assign acc_pre  = byte_acc && is_preamble_or_sfd_i;
    assign acc_dst  = byte_acc && is_dst_mac_i;
    assign acc_pl   = byte_acc && is_payload_or_fcs_i;

    assign buf_full = (cnt_q == CNT_W'(PAYLOAD_BUF_DEPTH));
    assign len_inc  = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);
    // DONE still emits the oldest buffered byte, so it joins the final count.
    assign len_fin  = buf_full ? len_inc : len_q;
    assign len_bad  = (32'(len_fin) < MIN_PAYLOAD_BYTES) || (32'(len_fin) > MAX_PAYLOAD_BYTES);

    // A preamble byte starts a new frame context; in DONE it lands after the report.
    assign clr = acc_pre && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (gmii_rx_data_i),
        .crc_o  (crc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            dst_sh_q        <= '0;
            src_sh_q        <= '0;
            et_hi_q         <= '0;
            et_cnt_q        <= 1'b0;
            crc_q           <= CRC32_INIT;
            err_q           <= 1'b0;
            for (int i = 0; i < int'(PAYLOAD_BUF_DEPTH); i++) begin
                buf_q[i] <= '0;
            end
            cnt_q           <= '0;
            len_q           <= '0;
            dst_mac_o       <= '0;
            src_mac_o       <= '0;
            ether_type_o    <= '0;
            hdr_valid_o     <= 1'b0;
            payload_data_o  <= '0;
            payload_valid_o <= 1'b0;
            payload_last_o  <= 1'b0;
            frame_done_o    <= 1'b0;
            fcs_ok_o        <= 1'b0;
            frame_err_o     <= 1'b0;
            frame_len_o     <= '0;
        end else begin
            hdr_valid_o     <= 1'b0;
            payload_valid_o <= 1'b0;
            payload_last_o  <= 1'b0;
            frame_done_o    <= 1'b0;
            fcs_ok_o        <= 1'b0;
            frame_err_o     <= 1'b0;
            frame_len_o     <= '0;

            unique case (state_q)
                ST_IDLE: begin
                    if (acc_dst) begin
                        dst_sh_q <= {dst_sh_q[39:0], gmii_rx_data_i};
                        crc_q    <= crc_d;
                        et_cnt_q <= 1'b0;
                        cnt_q    <= '0;
                        len_q    <= '0;
                        state_q  <= ST_HDR;
                    end
                end

                ST_HDR: begin
                    if (err_incomplete_i) begin
                        state_q <= ST_IDLE;
                    end else if (byte_acc && !is_preamble_or_sfd_i) begin
                        crc_q <= crc_d;
                        if (is_dst_mac_i) begin
                            dst_sh_q <= {dst_sh_q[39:0], gmii_rx_data_i};
                        end else if (is_src_mac_i) begin
                            src_sh_q <= {src_sh_q[39:0], gmii_rx_data_i};
                        end else if (is_ether_type_i) begin
                            et_hi_q  <= gmii_rx_data_i;
                            et_cnt_q <= 1'b1;
                            // Publish all fields together on the second EtherType byte
                            if (et_cnt_q) begin
                                hdr_valid_o  <= 1'b1;
                                dst_mac_o    <= dst_sh_q;
                                src_mac_o    <= src_sh_q;
                                ether_type_o <= {et_hi_q, gmii_rx_data_i};
                            end
                        end else begin
                            buf_q[0] <= gmii_rx_data_i;
                            cnt_q    <= CNT_W'(1);
                            state_q  <= ST_PAYLOAD;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (acc_pl) begin
                        crc_q    <= crc_d;
                        buf_q[0] <= gmii_rx_data_i;
                        for (int i = 1; i < int'(PAYLOAD_BUF_DEPTH); i++) begin
                            buf_q[i] <= buf_q[i-1];
                        end
                        if (buf_full) begin
                            payload_valid_o <= 1'b1;
                            payload_data_o  <= buf_q[PAYLOAD_BUF_DEPTH-1];
                            len_q           <= len_inc;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_q <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Remaining FCS_BYTES buffered bytes are the FCS and are dropped.
                    if (buf_full) begin
                        payload_valid_o <= 1'b1;
                        payload_last_o  <= 1'b1;
                        payload_data_o  <= buf_q[PAYLOAD_BUF_DEPTH-1];
                    end
                    frame_done_o <= 1'b1;
                    fcs_ok_o     <= (crc_q == CRC32_RESIDUE);
                    frame_err_o  <= err_q || !buf_full || len_bad;
                    frame_len_o  <= len_fin;
                    state_q      <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase

            if (clr) begin
                crc_q    <= CRC32_INIT;
                err_q    <= 1'b0;
                cnt_q    <= '0;
                len_q    <= '0;
                et_cnt_q <= 1'b0;
            end

            // Error pulses win over a same-cycle clear.
            if (err_preamble_sfd_i || err_incomplete_i) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule : eth_frame_extractor

// File: tb/tb_eth_frame_extractor.sv
// ---------------------------------------------------------------------------
// tb_eth_frame_extractor
// Directed bench for eth_frame_extractor: drives parser-flagged GMII frames
// and checks header, payload stream and end-of-frame status.
// ---------------------------------------------------------------------------
module tb_eth_frame_extractor;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_PRE  = 5'b10000;
    localparam logic [4:0] F_DST  = 5'b01000;
    localparam logic [4:0] F_SRC  = 5'b00100;
    localparam logic [4:0] F_ET   = 5'b00010;
    localparam logic [4:0] F_PL   = 5'b00001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        f_pre = 1'b0, f_dst = 1'b0, f_src = 1'b0, f_et = 1'b0, f_pl = 1'b0;
    logic        e_pre = 1'b0, e_inc = 1'b0;

    logic [47:0] dst_mac_o, src_mac_o;
    logic [15:0] ether_type_o;
    logic        hdr_valid_o;
    logic [7:0]  payload_data_o;
    logic        payload_valid_o, payload_last_o;
    logic        frame_done_o, fcs_ok_o, frame_err_o;
    logic [10:0] frame_len_o;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Monitor state (written only by the monitor process)
    logic [7:0]  beat_q[$];
    int          hdr_cnt = 0, done_cnt = 0, last_cnt = 0, last_idx = -1;
    logic [47:0] m_dst = '0, m_src = '0;
    logic [15:0] m_et = '0;
    logic        m_ok = 1'b0, m_err = 1'b0;
    logic [10:0] m_len = '0;

    eth_frame_extractor dut (
        .clk                  (clk),
        .rst                  (rst),
        .gmii_rx_data_i       (rx_data),
        .gmii_rx_valid_i      (rx_valid),
        .is_preamble_or_sfd_i (f_pre),
        .is_dst_mac_i         (f_dst),
        .is_src_mac_i         (f_src),
        .is_ether_type_i      (f_et),
        .is_payload_or_fcs_i  (f_pl),
        .err_preamble_sfd_i   (e_pre),
        .err_incomplete_i     (e_inc),
        .dst_mac_o            (dst_mac_o),
        .src_mac_o            (src_mac_o),
        .ether_type_o         (ether_type_o),
        .hdr_valid_o          (hdr_valid_o),
        .payload_data_o       (payload_data_o),
        .payload_valid_o      (payload_valid_o),
        .payload_last_o       (payload_last_o),
        .frame_done_o         (frame_done_o),
        .fcs_ok_o             (fcs_ok_o),
        .frame_err_o          (frame_err_o),
        .frame_len_o          (frame_len_o)
    );

    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (payload_valid_o) begin
                if (payload_last_o) begin
                    last_cnt++;
                    last_idx = beat_q.size();
                end
                beat_q.push_back(payload_data_o);
            end
            if (hdr_valid_o) begin
                hdr_cnt++;
                m_dst = dst_mac_o;
                m_src = src_mac_o;
                m_et  = ether_type_o;
            end
            if (frame_done_o) begin
                done_cnt++;
                m_ok  = fcs_ok_o;
                m_err = frame_err_o;
                m_len = frame_len_o;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_ref(input logic [7:0] bytes[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (bytes[i]) begin
            c = c ^ {24'h0, bytes[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic [4:0] f);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        {f_pre, f_dst, f_src, f_et, f_pl} = f;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, F_NONE);
    endtask

    task automatic send_preamble();
        repeat (7) drive(1'b1, 8'h55, F_PRE);
        drive(1'b1, 8'hD5, F_PRE);
    endtask

    // Sends preamble, header, plen payload bytes (value = index) and FCS.
    // When rst_at >= 0, reset is raised instead of sending payload byte rst_at.
    task automatic send_frame(input int plen, input logic [15:0] et, input bit bad_fcs,
                              input int rst_at);
        logic [7:0]  fr[$];
        logic [31:0] fcs;
        logic [4:0]  fl;
        for (int i = 1; i <= 6; i++) fr.push_back(8'(i));
        for (int i = 10; i <= 15; i++) fr.push_back(8'(i));
        fr.push_back(et[15:8]);
        fr.push_back(et[7:0]);
        for (int k = 0; k < plen; k++) fr.push_back(8'(k));
        fcs = ~crc_ref(fr);
        fr.push_back(fcs[7:0]);
        fr.push_back(fcs[15:8]);
        fr.push_back(fcs[23:16]);
        fr.push_back(fcs[31:24]);
        if (bad_fcs) fr[14+plen+1] = fr[14+plen+1] ^ 8'h10;
        send_preamble();
        for (int i = 0; i < fr.size(); i++) begin
            if (rst_at >= 0 && i == 14 + rst_at) begin
                @(posedge clk);
                #1;
                rst = 1'b1;
                rx_valid = 1'b0;
                {f_pre, f_dst, f_src, f_et, f_pl} = F_NONE;
                return;
            end
            fl = (i < 6) ? F_DST : (i < 12) ? F_SRC : (i < 14) ? F_ET : F_PL;
            drive(1'b1, fr[i], fl);
        end
        idle(12);
    endtask

    task automatic check_frame(input string tag, input int plen, input logic [15:0] et,
                               input logic exp_ok, input logic exp_err,
                               input int hb, input int db, input int lb, input int bb);
        int mism;
        int got;
        mism = 0;
        got  = beat_q.size() - bb;
        for (int k = 0; k < got && k < plen; k++) begin
            if (beat_q[bb+k] !== 8'(k)) mism++;
        end
        check({tag, "_hdr_pulses"}, 64'(hdr_cnt - hb), 64'd1);
        check({tag, "_dst"}, 64'(m_dst), 64'h0102_0304_0506);
        check({tag, "_src"}, 64'(m_src), 64'h0A0B_0C0D_0E0F);
        check({tag, "_etype"}, 64'(m_et), 64'(et));
        check({tag, "_beats"}, 64'(got), 64'(plen));
        check({tag, "_beat_data_errs"}, 64'(mism), 64'd0);
        check({tag, "_last_pulses"}, 64'(last_cnt - lb), 64'd1);
        check({tag, "_last_pos"}, 64'(last_idx), 64'(bb + plen - 1));
        check({tag, "_done_pulses"}, 64'(done_cnt - db), 64'd1);
        check({tag, "_fcs_ok"}, 64'(m_ok), 64'(exp_ok));
        check({tag, "_err"}, 64'(m_err), 64'(exp_err));
        check({tag, "_len"}, 64'(m_len), 64'(plen));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dst"}, 64'(dst_mac_o), 64'd0);
        check({tag, "_src"}, 64'(src_mac_o), 64'd0);
        check({tag, "_etype"}, 64'(ether_type_o), 64'd0);
        check({tag, "_hdr_valid"}, 64'(hdr_valid_o), 64'd0);
        check({tag, "_pdata"}, 64'(payload_data_o), 64'd0);
        check({tag, "_pvalid"}, 64'(payload_valid_o), 64'd0);
        check({tag, "_plast"}, 64'(payload_last_o), 64'd0);
        check({tag, "_done"}, 64'(frame_done_o), 64'd0);
        check({tag, "_fcs_ok"}, 64'(fcs_ok_o), 64'd0);
        check({tag, "_err"}, 64'(frame_err_o), 64'd0);
        check({tag, "_len"}, 64'(frame_len_o), 64'd0);
    endtask

    initial begin
        int hb, db, lb, bb;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        idle(4);

        // Minimal good frame
        hb = hdr_cnt; db = done_cnt; lb = last_cnt; bb = beat_q.size();
        send_frame(46, 16'h0800, 1'b0, -1);
        check_frame("min", 46, 16'h0800, 1'b1, 1'b0, hb, db, lb, bb);

        // Same frame with one FCS bit flipped
        hb = hdr_cnt; db = done_cnt; lb = last_cnt; bb = beat_q.size();
        send_frame(46, 16'h0800, 1'b1, -1);
        check_frame("badfcs", 46, 16'h0800, 1'b0, 1'b0, hb, db, lb, bb);

        // Header abort after 3 source MAC bytes
        hb = hdr_cnt; db = done_cnt; bb = beat_q.size();
        send_preamble();
        for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i + 8'h20), F_DST);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(i + 8'h30), F_SRC);
        drive(1'b0, 8'h00, F_NONE);
        e_inc = 1'b1;
        drive(1'b0, 8'h00, F_NONE);
        e_inc = 1'b0;
        idle(12);
        check("abort_hdr_pulses", 64'(hdr_cnt - hb), 64'd0);
        check("abort_done_pulses", 64'(done_cnt - db), 64'd0);
        check("abort_beats", 64'(beat_q.size() - bb), 64'd0);
        check("abort_dst_kept", 64'(dst_mac_o), 64'h0102_0304_0506);
        check("abort_etype_kept", 64'(ether_type_o), 64'h0800);

        // Good frame following the abort
        hb = hdr_cnt; db = done_cnt; lb = last_cnt; bb = beat_q.size();
        send_frame(60, 16'h86DD, 1'b0, -1);
        check_frame("after_abort", 60, 16'h86DD, 1'b1, 1'b0, hb, db, lb, bb);

        // Runt frame
        hb = hdr_cnt; db = done_cnt; lb = last_cnt; bb = beat_q.size();
        send_frame(20, 16'h0806, 1'b0, -1);
        check_frame("runt", 20, 16'h0806, 1'b1, 1'b1, hb, db, lb, bb);

        // Back-to-back maximum-size frames, 12-cycle IFG
        hb = hdr_cnt; db = done_cnt; lb = last_cnt; bb = beat_q.size();
        send_frame(1500, 16'h0800, 1'b0, -1);
        check_frame("max1", 1500, 16'h0800, 1'b1, 1'b0, hb, db, lb, bb);
        hb = hdr_cnt; db = done_cnt; lb = last_cnt; bb = beat_q.size();
        send_frame(1500, 16'h0800, 1'b0, -1);
        check_frame("max2", 1500, 16'h0800, 1'b1, 1'b0, hb, db, lb, bb);

        // Reset at payload byte 100
        db = done_cnt;
        send_frame(200, 16'h0800, 1'b0, 100);
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("midrst");
        rst = 1'b0;
        idle(12);
        check("midrst_done_pulses", 64'(done_cnt - db), 64'd0);

        // Clean frame after reset
        hb = hdr_cnt; db = done_cnt; lb = last_cnt; bb = beat_q.size();
        send_frame(46, 16'h88B5, 1'b0, -1);
        check_frame("post_rst", 46, 16'h88B5, 1'b1, 1'b0, hb, db, lb, bb);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_eth_frame_extractor
